// File: rtl/hsadc_capture_core.sv
// Multi-channel high-speed ADC capture engine: divided encode strobe, delayed
// capture, channel packing into a framed single-entry AXI-Stream output.
module hsadc_capture_core #(
  parameter int NUM_CHANNELS  = 2,
  parameter int SAMPLE_WIDTH  = 8,
  parameter int DIV_WIDTH     = 16,
  parameter int CAPTURE_DELAY = 1,
  parameter int PACKET_LEN    = 64,
  parameter int OVF_WIDTH     = 16
) (
  input  logic                                 sample_clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [DIV_WIDTH-1:0]                 divider,
  input  logic                                 mode_s1,
  input  logic                                 mode_s2,
  input  logic                                 mode_dfs,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  output logic                                 adc_enc,
  output logic                                 adc_s1,
  output logic                                 adc_s2,
  output logic                                 adc_dfs,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 busy,
  output logic                                 overflow,
  input  logic                                 overflow_clear,
  output logic [OVF_WIDTH-1:0]                 ovf_count
);

  localparam int DW        = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int PKT_W     = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam int MIN_DIV_I = (CAPTURE_DELAY + 1 > 2) ? CAPTURE_DELAY + 1 : 2;

  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(MIN_DIV_I);
  localparam logic [DIV_WIDTH-1:0] CAP_AT   = DIV_WIDTH'(CAPTURE_DELAY);
  localparam logic [PKT_W-1:0]     PKT_LAST = PKT_W'(PACKET_LEN - 1);
  localparam logic [OVF_WIDTH-1:0] OVF_MAX  = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 enc_q, enc_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 dfs_q, dfs_d;
  logic [DW-1:0]        tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic                 ovf_q, ovf_d;
  logic [OVF_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [DIV_WIDTH-1:0] div_eff;
  logic [DW-1:0]        packed_word;
  logic                 capture;
  logic                 handshake;
  logic                 load;
  logic                 drop;

  // Period never shorter than the capture offset, and never below two cycles.
  always_comb begin
    div_eff = (divider > MIN_DIV) ? divider : MIN_DIV;
  end

  // Channel 0 lands in the most significant field of the stream word.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      packed_word[(NUM_CHANNELS-1-i)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        adc_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // Sequencer: a running period always completes before returning to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ST_RUN;
          div_d   = div_eff;
        end
      end
      ST_RUN: begin
        if (cnt_q == div_q - 1'b1) begin
          cnt_d = '0;
          if (!enable) begin
            state_d = ST_IDLE;
          end else begin
            div_d = div_eff;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    enc_d = (state_d == ST_RUN) && (cnt_d == '0);
  end

  // Converter configuration only tracks its inputs while the ADC is idle.
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    dfs_d = dfs_q;
    if (state_q == ST_IDLE) begin
      s1_d  = mode_s1;
      s2_d  = mode_s2;
      dfs_d = mode_dfs;
    end
  end

  always_comb begin
    capture   = (state_q == ST_RUN) && (cnt_q == CAP_AT);
    handshake = tvalid_q && m_axis_tready;
    load      = capture && (!tvalid_q || m_axis_tready);
    drop      = capture && tvalid_q && !m_axis_tready;
  end

  // Output slot and packet position; tlast is decided from the index the
  // loaded word will hold once the current handshake has been counted.
  always_comb begin
    pkt_d    = pkt_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (handshake) begin
      pkt_d = tlast_q ? '0 : pkt_q + 1'b1;
    end
    if (load) begin
      tdata_d  = packed_word;
      tlast_d  = (pkt_d == PKT_LAST);
      tvalid_d = 1'b1;
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  // A clear in the same cycle as a drop takes priority over the increment.
  always_comb begin
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (overflow_clear) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != OVF_MAX) begin
        ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= MIN_DIV;
      enc_q     <= 1'b0;
      s1_q      <= 1'b1;
      s2_q      <= 1'b0;
      dfs_q     <= 1'b1;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      pkt_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      enc_q     <= enc_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      dfs_q     <= dfs_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      pkt_q     <= pkt_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  always_comb begin
    adc_enc       = enc_q;
    adc_s1        = s1_q;
    adc_s2        = s2_q;
    adc_dfs       = dfs_q;
    m_axis_tdata  = tdata_q;
    m_axis_tvalid = tvalid_q;
    m_axis_tlast  = tlast_q;
    busy          = (state_q == ST_RUN);
    overflow      = ovf_q;
    ovf_count     = ovf_cnt_q;
  end

endmodule

// File: tb/tb_hsadc_capture_core.sv
// Randomized bench for hsadc_capture_core: a period-level reference model
// fills an expected-word queue, an independent monitor drains it on handshakes.
module tb_hsadc_capture_core;

  localparam int NC   = 2;
  localparam int SW   = 8;
  localparam int DIVW = 16;
  localparam int CD   = 1;
  localparam int PL   = 4;
  localparam int OVFW = 4;
  localparam int DW   = NC * SW;

  logic            sample_clk;
  logic            reset;
  logic            enable;
  logic [DIVW-1:0] divider;
  logic            mode_s1, mode_s2, mode_dfs;
  logic [DW-1:0]   adc_data;
  logic            adc_enc, adc_s1, adc_s2, adc_dfs;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;
  logic            overflow;
  logic            overflow_clear;
  logic [OVFW-1:0] ovf_count;

  hsadc_capture_core #(
    .NUM_CHANNELS (NC),
    .SAMPLE_WIDTH (SW),
    .DIV_WIDTH    (DIVW),
    .CAPTURE_DELAY(CD),
    .PACKET_LEN   (PL),
    .OVF_WIDTH    (OVFW)
  ) dut (
    .sample_clk    (sample_clk),
    .reset         (reset),
    .enable        (enable),
    .divider       (divider),
    .mode_s1       (mode_s1),
    .mode_s2       (mode_s2),
    .mode_dfs      (mode_dfs),
    .adc_data      (adc_data),
    .adc_enc       (adc_enc),
    .adc_s1        (adc_s1),
    .adc_s2        (adc_s2),
    .adc_dfs       (adc_dfs),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .overflow      (overflow),
    .overflow_clear(overflow_clear),
    .ovf_count     (ovf_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sample_clk = 1'b0;
    forever #5 sample_clk = ~sample_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 0;
  bit rnd_data = 0;

  // Reference model: period phase, one-slot output occupancy, drop counter.
  bit m_run     = 0;
  int m_phase   = 0;
  int m_period  = 2;
  bit m_valid   = 0;
  int m_loaded  = 0;
  bit m_ovf     = 0;
  int m_ovf_cnt = 0;
  bit m_s1 = 1, m_s2 = 0, m_dfs = 1;
  bit m_enc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_period(input logic [DIVW-1:0] d);
    int p;
    p = int'(d);
    if (p < CD + 1) p = CD + 1;
    if (p < 2) p = 2;
    return p;
  endfunction

  function automatic logic [DW-1:0] pack_ref(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r = (r << SW) | DW'(d[i*SW +: SW]);
    return r;
  endfunction

  always @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_phase = 0; m_period = 2; m_valid = 0; m_loaded = 0;
      m_ovf = 0; m_ovf_cnt = 0; m_s1 = 1; m_s2 = 0; m_dfs = 1; m_enc = 0;
      exp_q.delete();
    end else begin
      bit cap, accept_slot, dropped;
      cap         = m_run && (m_phase == CD);
      accept_slot = !m_valid || m_axis_tready;
      dropped     = cap && !accept_slot;
      if (cap && accept_slot) begin
        exp_q.push_back({((m_loaded % PL) == PL - 1), pack_ref(adc_data)});
        m_loaded++;
        m_valid = 1;
      end else if (m_valid && m_axis_tready) begin
        m_valid = 0;
      end
      if (overflow_clear) begin
        m_ovf = 0; m_ovf_cnt = 0;
      end else if (dropped) begin
        m_ovf = 1;
        if (m_ovf_cnt < (1 << OVFW) - 1) m_ovf_cnt++;
      end
      if (!m_run) begin
        m_s1 = mode_s1; m_s2 = mode_s2; m_dfs = mode_dfs;
        if (enable) begin
          m_run = 1; m_phase = 0; m_period = eff_period(divider);
        end
      end else if (m_phase == m_period - 1) begin
        m_phase = 0;
        if (!enable) m_run = 0;
        else m_period = eff_period(divider);
      end else begin
        m_phase++;
      end
      m_enc = m_run && (m_phase == 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge sample_clk) begin
    if (mon_en && !reset) begin
      chk("adc_enc", 32'(adc_enc), 32'(m_enc));
      chk("busy", 32'(busy), 32'(m_run));
      chk("tvalid", 32'(m_axis_tvalid), 32'(m_valid));
      chk("modes", 32'({adc_s1, adc_s2, adc_dfs}), 32'({m_s1, m_s2, m_dfs}));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("ovf_count", 32'(ovf_count), 32'(m_ovf_cnt));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL word_unexpected: got 0x%0h with queue empty expected no word",
                   {m_axis_tlast, m_axis_tdata});
        end else begin
          logic [DW:0] w;
          w = exp_q.pop_front();
          chk("word_tlast_tdata", 32'({m_axis_tlast, m_axis_tdata}), 32'(w));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sample_clk);
      #1;
      if (rnd_data) adc_data = DW'($urandom);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 100) begin
      step(1);
      k++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    chk(name, 32'({adc_enc, adc_s1, adc_s2, adc_dfs, m_axis_tvalid, m_axis_tlast,
                   busy, overflow}), 32'b0_1_0_1_0_0_0_0);
    chk({name, "_data_cnt"}, 32'({m_axis_tdata, ovf_count}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    reset = 1; enable = 0; divider = 16'd10; mode_s1 = 1; mode_s2 = 0; mode_dfs = 1;
    adc_data = '0; m_axis_tready = 1; overflow_clear = 0;
    repeat (3) @(posedge sample_clk);
    #1;
    check_reset_values("reset_values");
    reset = 0;
    mon_en = 1;

    // Fixed channel values, divider 10, packets of four.
    adc_data = {8'h3C, 8'hA5};
    enable = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (m_axis_tvalid) found = 1;
    end
    chk("pack_a53c", 32'(m_axis_tdata), 32'h0000A53C);
    rnd_data = 1;
    step(90);

    // Clamped periods.
    divider = 16'd0;  step(20);
    divider = 16'd1;  step(20);

    // Stall for 35 cycles from idle at divider 10: three drops.
    enable = 0;
    wait_idle("idle_before_stall");
    step(4);
    overflow_clear = 1; step(1); overflow_clear = 0;
    divider = 16'd10; m_axis_tready = 0; enable = 1;
    step(35);
    chk("stall_ovf_count", 32'(ovf_count), 32'd3);
    chk("stall_overflow", 32'(overflow), 32'd1);
    overflow_clear = 1; step(1); overflow_clear = 0;
    chk("clear_ovf_count", 32'(ovf_count), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);

    // Saturation at all-ones with the shortest period.
    divider = 16'd0;
    step(50);
    chk("sat_ovf_count", 32'(ovf_count), 32'((1 << OVFW) - 1));
    m_axis_tready = 1;
    step(10);

    // Mode change during RUN is ignored; enable dropped mid-period.
    mode_s1 = 0; divider = 16'd10;
    step(13);
    enable = 0;
    wait_idle("idle_after_enable_drop");
    step(2);
    chk("mode_s1_idle", 32'(adc_s1), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) divider = DIVW'($urandom_range(0, 12));
      m_axis_tready  = ($urandom_range(0, 3) != 0);
      overflow_clear = ($urandom_range(0, 29) == 0);
      {mode_s1, mode_s2, mode_dfs} = 3'($urandom);
      step(1);
    end
    overflow_clear = 0;

    // Asynchronous reset while a word is stalled.
    enable = 1; divider = 16'd3; m_axis_tready = 0;
    step(20);
    chk("pre_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
    #2;
    reset = 1;
    #1;
    check_reset_values("async_reset_values");
    enable = 0; m_axis_tready = 1;
    step(2);
    reset = 0;
    step(10);
    chk("no_stale_word", 32'(m_axis_tvalid), 32'd0);

    // Drain.
    enable = 1; step(40);
    enable = 0;
    wait_idle("final_idle");
    step(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hsadc_capture_core.md
Name: hsadc_capture_core

Overview:
- Parametrised capture engine for the multi-channel high-speed ADC.
- Generates a single shared encode strobe at a runtime-programmable divider rate and captures all channels on a fixed-delay cycle after each strobe.
- Packs the channels into one AXI-Stream word with packet framing, and counts samples dropped on downstream backpressure.
- Sits between the ADC pins and the async stream FIFO, in the sample_clk domain.

Parameters:
- NUM_CHANNELS, 2, number of ADC channels captured per strobe (1..8).
- SAMPLE_WIDTH, 8, bits per channel sample.
- DIV_WIDTH, 16, width of the runtime divider input.
- CAPTURE_DELAY, 1, cycles from encode-high cycle to data capture cycle (1..7).
- PACKET_LEN, 64, accepted words per packet; tlast on the last word (>=1).
- OVF_WIDTH, 16, width of the dropped-sample counter.

Ports:
- sample_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- divider  in  DIV_WIDTH  sample period in sample_clk cycles.
- mode_s1  in  1  ADC S1 config, applied while idle.
- mode_s2  in  1  ADC S2 config, applied while idle.
- mode_dfs  in  1  ADC output format, applied while idle.
- adc_data  in  NUM_CHANNELS*SAMPLE_WIDTH  channel buses; channel 0 in LSBs.
- adc_enc  out  1  shared encode strobe, fanned out to all channel encode pins.
- adc_s1  out  1  registered S1.
- adc_s2  out  1  registered S2.
- adc_dfs  out  1  registered DFS.
- m_axis_tdata  out  NUM_CHANNELS*SAMPLE_WIDTH  packed sample; channel 0 in MSBs.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of packet.
- busy  out  1  high in RUN state.
- overflow  out  1  sticky; set on first dropped sample.
- overflow_clear  in  1  one-cycle pulse; clears overflow and ovf_count.
- ovf_count  out  OVF_WIDTH  saturating dropped-sample count.

Behaviour:
- Reset values:
  - adc_enc=0, adc_s1=1, adc_s2=0, adc_dfs=1.
  - tvalid=0, tdata=0, tlast=0.
  - busy=0, overflow=0, ovf_count=0.
  - State IDLE, period counter 0, packet counter 0.
- Reset mid-operation discards the held word and all counters immediately.
- Effective period: div_eff = max(divider, CAPTURE_DELAY+1, 2). It is latched into div_q only when entering RUN and at each period start (cnt==0); divider changes mid-period have no effect until then.
- State IDLE:
  - adc_s1/s2/dfs follow mode_* each cycle.
  - adc_enc=0.
  - enable=1 -> RUN with cnt=0 on the next cycle.
- State RUN:
  - adc_s1/s2/dfs frozen.
  - cnt counts 0..div_q-1 and wraps.
  - adc_enc=1 exactly in cycles where cnt==0 (registered output, one cycle wide).
  - At cnt==CAPTURE_DELAY: sample adc_data and pack reversed (channel 0 -> MSB field).
  - At cnt==div_q-1: if enable==0 -> IDLE, else wrap.
  - Enable deassertion mid-period always completes the period, including its capture.
- Output register (single entry):
  - Capture while tvalid==0, or tvalid&&tready in the same cycle -> load word, tvalid=1 next cycle.
  - Capture while tvalid&&!tready -> new word dropped, held word unchanged, overflow<=1, ovf_count+1 saturating at all-ones.
  - tdata/tlast stable while tvalid&&!tready.
  - tvalid falls on handshake unless a new word loads in the same cycle.
- Latency: capture cycle -> tvalid high on the following cycle.
- Packet framing:
  - tlast=1 on the word that will be the PACKET_LEN-th accepted word of the packet.
  - Packet counter advances on handshake and wraps to 0 after the tlast handshake.
  - Dropped samples do not advance it.
  - PACKET_LEN=1 -> tlast on every word.
- Packet counter is not reset by enable toggling; only reset clears it.
- overflow_clear coinciding with a drop: the clear wins for this cycle's increment; the count becomes 0 and overflow 0.

Test Plan:
- divider=10, enable=1, tready=1 -> adc_enc high once every 10 cycles; tvalid pulses 1 cycle after each capture at cnt==1. With ch0=0xA5, ch1=0x3C, tdata=0xA53C.
- divider=0 and divider=1 -> period clamps to 2; enc toggles 1,0,1,0; one word every 2 cycles.
- tready=0 for 35 cycles at divider=10 -> first word held stable; 3 drops; ovf_count=3, overflow=1. Then overflow_clear -> both 0.
- PACKET_LEN=4, tready=1, 9 samples -> tlast on words 4 and 8 only; word 9 tlast=0.
- enable dropped at cnt==3 of a 10-cycle period -> capture still emitted; IDLE after cnt==9; mode_s1=0 now propagates to adc_s1 within 1 cycle. A mode change during RUN is ignored.
- reset asserted while tvalid=1 and tready=0 -> all outputs return to reset values asynchronously; after release, no stale word appears.
